hdr_byte_tracker: RTL
=====================

// Module: hdr_byte_tracker
// PURPOSE
//  Next-generation header byte tracker for the Ethernet parser datapath; tracks byte position per frame.
//  Counts valid bytes per accepted beat from keep; runtime header length latched per frame.
//  Flags the lane where payload starts in the boundary beat; reports runt frames and total frame length.
//  Sits beside the beat pipeline and drives header extract / payload steer control.
// PARAMETERS
//  DATA_WIDTH     64  beat width in bits, multiple of 8; BPB = DATA_WIDTH/8, LANE_W = $clog2(BPB)
//  MIN_HDR_BYTES  14  header length used when hdr_len == 0
//  MAX_HDR_BYTES  64  hdr_len clamp ceiling
//  CNT_WIDTH      16  frame byte counter width, saturating
// PORTS
//  clk             in   1          single clock, rising edge
//  rst             in   1          synchronous reset, active-high
//  frame_start     in   1          1-cycle pulse, start of frame; latches hdr_len
//  hdr_len         in   8          header length in bytes for the new frame
//  beat_accept     in   1          data beat consumed this cycle
//  beat_keep       in   BPB        byte-valid mask, contiguous from lane 0
//  beat_last       in   1          accepted beat is last of frame
//  in_header       out  1          high while header bytes are outstanding
//  beat_offset     out  CNT_WIDTH  frame byte offset of lane 0 of next beat (= count)
//  header_done     out  1          1-cycle pulse, header completed
//  hdr_split       out  1          with header_done: header ended mid-beat
//  hdr_split_lane  out  LANE_W     with header_done: first payload lane in boundary beat
//  runt_err        out  1          1-cycle pulse, beat_last before header completed
//  frame_done      out  1          1-cycle pulse on beat_last
//  frame_bytes     out  CNT_WIDTH  total frame bytes, valid with frame_done, held after
// BEHAVIOUR
//  Reset: state IDLE, count 0, hdr_len_q 0; all outputs 0.
//  Latching: hdr_len_q = MIN_HDR_BYTES if hdr_len==0; MAX_HDR_BYTES if hdr_len>MAX; else hdr_len.
//  States: IDLE -> HDR on frame_start; HDR -> PAY on header completion; HDR/PAY -> IDLE on beat_last.
//  frame_start in any state aborts the current frame silently (no frame_done) and restarts in HDR.
//  Beats accepted in IDLE are ignored; count unchanged, no pulses.
//  nb = popcount(beat_keep), 0..BPB; next = count + nb, saturating at 2^CNT_WIDTH-1.
//  frame_start with beat_accept in the same cycle: beat counted as first beat of new frame.
//  HDR, accepted beat, next >= hdr_len_q:
//   - in_header <= 0; header_done, hdr_split, hdr_split_lane registered (1-cycle latency).
//   - hdr_split = (next > hdr_len_q); hdr_split_lane = (hdr_len_q - count) mod BPB.
//  HDR, accepted beat, next < hdr_len_q, beat_last: runt_err and frame_done pulse; -> IDLE.
//  Header completion and beat_last in the same beat: header_done and frame_done pulse together; no runt_err.
//  PAY: count <= next on every accepted beat.
//  Every beat_last: frame_bytes <= next, frame_done pulses next cycle; count held until next frame_start.
//  in_header: high in HDR only. beat_offset: registered count; 0 after frame_start.
//  Non-SYNTHESIS assertions: keep contiguous; beat_keep != 0 unless beat_last;
//   header_done and runt_err never in the same cycle.
// CONFIGURATION
//  HDR_LEN_UPDATE_EN defined: adds inputs hdr_len_upd (1) and hdr_len_add (8) for VLAN/option growth.
//   - In HDR, hdr_len_upd adds hdr_len_add to hdr_len_q, clamped to MAX_HDR_BYTES.
//   - Same cycle as an accepted beat: update applied before the completion compare.
//   - Ignored outside HDR.
//  Undefined: ports absent; hdr_len_q fixed from frame_start for the whole frame.
// TESTING (DATA_WIDTH=64)
//  hdr_len=18, 4 beats keep 0xFF, last on beat 4
//   -> header_done 1 cycle after beat 3, hdr_split=1, hdr_split_lane=2; frame_bytes=32.
//  hdr_len=16, beats keep 0xFF
//   -> header_done after beat 2, hdr_split=0, hdr_split_lane=0; beat_offset sequence 0,8,16.
//  hdr_len=18, beat 1 keep 0xFF, beat 2 keep 0x0F + last
//   -> runt_err=1, frame_done=1, frame_bytes=12, in_header=0.
//  hdr_len=0 -> completes at 14 bytes; hdr_len=200 -> completes at 64 bytes.
//  frame_start + beat_accept same cycle mid-payload of frame A
//   -> no frame_done for A; new frame count=8 after that beat.
//  HDR_LEN_UPDATE_EN: hdr_len=14, hdr_len_add=4 with beat 2
//   -> no completion at 16; header_done after beat 3, hdr_split_lane=2.
//  rst asserted mid-HDR -> next cycle all outputs 0, state IDLE; later beats ignored until frame_start.

Source files
------------

// File: rtl/hdr_byte_tracker_if.sv
// Beat-side control bundle between the parser pipeline and hdr_byte_tracker.
// HDR_LEN_UPDATE_EN adds the header-growth inputs hdr_len_upd / hdr_len_add.
interface hdr_byte_tracker_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
);
    localparam int BPB    = DATA_WIDTH / 8;
    localparam int LANE_W = (BPB > 1) ? $clog2(BPB) : 1;

    logic                 frame_start;
    logic [7:0]           hdr_len;
    logic                 beat_accept;
    logic [BPB-1:0]       beat_keep;
    logic                 beat_last;
`ifdef HDR_LEN_UPDATE_EN
    logic                 hdr_len_upd;
    logic [7:0]           hdr_len_add;
`endif
    logic                 in_header;
    logic [CNT_WIDTH-1:0] beat_offset;
    logic                 header_done;
    logic                 hdr_split;
    logic [LANE_W-1:0]    hdr_split_lane;
    logic                 runt_err;
    logic                 frame_done;
    logic [CNT_WIDTH-1:0] frame_bytes;

    modport master (
        output frame_start, hdr_len, beat_accept, beat_keep, beat_last,
`ifdef HDR_LEN_UPDATE_EN
        output hdr_len_upd, hdr_len_add,
`endif
        input  in_header, beat_offset, header_done, hdr_split, hdr_split_lane,
        input  runt_err, frame_done, frame_bytes
    );

    modport slave (
        input  frame_start, hdr_len, beat_accept, beat_keep, beat_last,
`ifdef HDR_LEN_UPDATE_EN
        input  hdr_len_upd, hdr_len_add,
`endif
        output in_header, beat_offset, header_done, hdr_split, hdr_split_lane,
        output runt_err, frame_done, frame_bytes
    );
endinterface

// File: rtl/hdr_byte_tracker.sv
// Per-frame byte position tracker: header completion, payload start lane, runt and length.
// Optional macro HDR_LEN_UPDATE_EN enables in-header growth of the header length.
module hdr_byte_tracker #(
    parameter int DATA_WIDTH    = 64,
    parameter int MIN_HDR_BYTES = 14,
    parameter int MAX_HDR_BYTES = 64,
    parameter int CNT_WIDTH     = 16
) (
    input  logic              clk,
    input  logic              rst,
    hdr_byte_tracker_if.slave bus
);
    localparam int BPB    = DATA_WIDTH / 8;
    localparam int LANE_W = (BPB > 1) ? $clog2(BPB) : 1;
    localparam int NB_W   = $clog2(BPB + 1);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY} state_t;

    state_t               r_state, w_state_cur, w_state_next;
    logic [CNT_WIDTH-1:0] r_count, w_count_cur, w_count_next, w_next_cnt, w_diff;
    logic [CNT_WIDTH:0]   w_sum;
    logic [7:0]           r_hdr_len, w_hdr_cur, w_hdr_next, w_hdr_start;
    logic [NB_W-1:0]      w_nb;
    logic                 r_header_done, w_header_done_next;
    logic                 r_hdr_split, w_hdr_split_next;
    logic [LANE_W-1:0]    r_split_lane, w_split_lane_next;
    logic                 r_runt_err, w_runt_err_next;
    logic                 r_frame_done, w_frame_done_next;
    logic [CNT_WIDTH-1:0] r_frame_bytes, w_frame_bytes_next;

    always_comb begin
        w_nb = '0;
        for (int i = 0; i < BPB; i++) begin
            w_nb = w_nb + NB_W'(bus.beat_keep[i]);
        end
    end

    // hdr_len of 0 means "use the minimum Ethernet header"
    always_comb begin
        if (bus.hdr_len == 8'd0)
            w_hdr_start = 8'(MIN_HDR_BYTES);
        else if (bus.hdr_len > 8'(MAX_HDR_BYTES))
            w_hdr_start = 8'(MAX_HDR_BYTES);
        else
            w_hdr_start = bus.hdr_len;
    end

`ifdef HDR_LEN_UPDATE_EN
    logic [8:0] w_hdr_grow_sum;
    logic [7:0] w_hdr_grown;
    assign w_hdr_grow_sum = {1'b0, r_hdr_len} + {1'b0, bus.hdr_len_add};
    assign w_hdr_grown    = (w_hdr_grow_sum > 9'(MAX_HDR_BYTES)) ? 8'(MAX_HDR_BYTES)
                                                                  : w_hdr_grow_sum[7:0];
`endif

    always_comb begin
        // frame_start redefines the frame context before the beat is applied
        w_state_cur = r_state;
        w_count_cur = r_count;
        w_hdr_cur   = r_hdr_len;
        if (bus.frame_start) begin
            w_state_cur = S_HDR;
            w_count_cur = '0;
            w_hdr_cur   = w_hdr_start;
        end
`ifdef HDR_LEN_UPDATE_EN
        else if (r_state == S_HDR && bus.hdr_len_upd) begin
            w_hdr_cur = w_hdr_grown;
        end
`endif
        w_sum      = {1'b0, w_count_cur} + (CNT_WIDTH + 1)'(w_nb);
        w_next_cnt = w_sum[CNT_WIDTH] ? '1 : w_sum[CNT_WIDTH-1:0];
        w_diff     = CNT_WIDTH'(w_hdr_cur) - w_count_cur;

        w_state_next       = w_state_cur;
        w_count_next       = w_count_cur;
        w_hdr_next         = w_hdr_cur;
        w_header_done_next = 1'b0;
        w_hdr_split_next   = 1'b0;
        w_split_lane_next  = '0;
        w_runt_err_next    = 1'b0;
        w_frame_done_next  = 1'b0;
        w_frame_bytes_next = r_frame_bytes;

        if (bus.beat_accept && w_state_cur != S_IDLE) begin
            w_count_next = w_next_cnt;
            if (w_state_cur == S_HDR) begin
                if (w_next_cnt >= CNT_WIDTH'(w_hdr_cur)) begin
                    w_state_next       = S_PAY;
                    w_header_done_next = 1'b1;
                    w_hdr_split_next   = (w_next_cnt > CNT_WIDTH'(w_hdr_cur));
                    w_split_lane_next  = LANE_W'(w_diff % CNT_WIDTH'(BPB));
                end else if (bus.beat_last) begin
                    w_runt_err_next = 1'b1;
                end
            end
            if (bus.beat_last) begin
                w_state_next       = S_IDLE;
                w_frame_done_next  = 1'b1;
                w_frame_bytes_next = w_next_cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_hdr_len     <= '0;
            r_header_done <= 1'b0;
            r_hdr_split   <= 1'b0;
            r_split_lane  <= '0;
            r_runt_err    <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_bytes <= '0;
        end else begin
            r_state       <= w_state_next;
            r_count       <= w_count_next;
            r_hdr_len     <= w_hdr_next;
            r_header_done <= w_header_done_next;
            r_hdr_split   <= w_hdr_split_next;
            r_split_lane  <= w_split_lane_next;
            r_runt_err    <= w_runt_err_next;
            r_frame_done  <= w_frame_done_next;
            r_frame_bytes <= w_frame_bytes_next;
        end
    end

    assign bus.in_header      = (r_state == S_HDR);
    assign bus.beat_offset    = r_count;
    assign bus.header_done    = r_header_done;
    assign bus.hdr_split      = r_hdr_split;
    assign bus.hdr_split_lane = r_split_lane;
    assign bus.runt_err       = r_runt_err;
    assign bus.frame_done     = r_frame_done;
    assign bus.frame_bytes    = r_frame_bytes;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && bus.beat_accept) begin
            assert (((bus.beat_keep + BPB'(1)) & bus.beat_keep) == '0)
                else $error("beat_keep not contiguous from lane 0");
            assert (bus.beat_keep != '0 || bus.beat_last)
                else $error("empty beat_keep on non-last beat");
        end
        if (!rst) begin
            assert (!(r_header_done && r_runt_err))
                else $error("header_done and runt_err together");
        end
    end
`endif
endmodule
